// File: rtl/gpio_cond_pkg.sv
// Shared encodings and helpers for the GPIO input conditioner.
package gpio_cond_pkg;

  typedef enum logic [1:0] {
    ST_LOW     = 2'd0,
    ST_HI_PEND = 2'd1,
    ST_HIGH    = 2'd2,
    ST_LO_PEND = 2'd3
  } db_state_e;

  localparam logic [7:0] GLITCH_MAX = 8'd255;

  // Bring-up counter: sticks at GLITCH_MAX instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == GLITCH_MAX) begin
      sat_inc8 = v;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/gpio_debounce_ch.sv
// One GPIO channel: synchroniser, debounce FSM/counter, edge pulses, glitch counter.
module gpio_debounce_ch
  import gpio_cond_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16000,
  parameter int CNT_W       = $clog2(DB_CYCLES)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pad_i,
  input  logic       pad_ie,
  output logic       s_o,
  output logic       db_o,
  output logic       rise_p,
  output logic       fall_p,
  output logic [7:0] glitch_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  db_state_e              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   db_q, db_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [7:0]             glitch_q, glitch_d;
  logic                   s;
  logic                   abort;

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pad_i};
    state_d  = state_q;
    cnt_d    = cnt_q;
    abort    = 1'b0;
    case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_HI_PEND;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ST_HI_PEND: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
          abort   = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_LO_PEND;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      ST_LO_PEND: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = CNT_ZERO;
          abort   = 1'b1;
        end else if (cnt_q == CNT_MAX) begin
          state_d = ST_LOW;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = CNT_ZERO;
      end
    endcase

    // db tracks the next state so it flips on the same edge as the FSM settles.
    db_d     = (state_d == ST_HIGH) || (state_d == ST_LO_PEND);
    rise_d   = db_d & ~db_q & pad_ie;
    fall_d   = ~db_d & db_q & pad_ie;
    if (abort) begin
      glitch_d = sat_inc8(glitch_q);
    end else begin
      glitch_d = glitch_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= {SYNC_STAGES{1'b0}};
      state_q  <= ST_LOW;
      cnt_q    <= CNT_ZERO;
      db_q     <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 8'd0;
    end else begin
      sync_q   <= sync_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      db_q     <= db_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  assign s_o        = s;
  assign db_o       = db_q;
  assign rise_p     = rise_q;
  assign fall_p     = fall_q;
  assign glitch_cnt = glitch_q;

endmodule

// File: rtl/gpio_in_cond.sv
// GPIO input conditioner: per-channel debounce plus bypass/input-enable gating
// toward the SoC i_ival inputs.
module gpio_in_cond
  import gpio_cond_pkg::*;
#(
  parameter int NUM_GPIO    = 2,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16000,
  parameter int CNT_W       = $clog2(DB_CYCLES)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_GPIO-1:0]   pad_i,
  input  logic [NUM_GPIO-1:0]   pad_ie,
  input  logic                  bypass,
  output logic [NUM_GPIO-1:0]   ival,
  output logic [NUM_GPIO-1:0]   rise_p,
  output logic [NUM_GPIO-1:0]   fall_p,
  output logic [NUM_GPIO*8-1:0] glitch_cnt
);

  logic [NUM_GPIO-1:0] s;
  logic [NUM_GPIO-1:0] db;

  for (genvar k = 0; k < NUM_GPIO; k++) begin : g_ch
    gpio_debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES),
      .CNT_W       (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .pad_i      (pad_i[k]),
      .pad_ie     (pad_ie[k]),
      .s_o        (s[k]),
      .db_o       (db[k]),
      .rise_p     (rise_p[k]),
      .fall_p     (fall_p[k]),
      .glitch_cnt (glitch_cnt[8*k +: 8])
    );

    // Same AND gating as the pad wrapper; the only combinational path.
    assign ival[k] = (bypass ? s[k] : db[k]) & pad_ie[k];
  end

endmodule

// File: tb/tb_gpio_in_cond.sv
// Scoreboard bench for gpio_in_cond with DB_CYCLES=4: expected edge pulses are
// queued by the stimulus and matched by an independent monitor.
module tb_gpio_in_cond;

  logic        clk;
  logic        rst;
  logic [1:0]  pad_i;
  logic [1:0]  pad_ie;
  logic        bypass;
  logic [1:0]  ival;
  logic [1:0]  rise_p;
  logic [1:0]  fall_p;
  logic [15:0] glitch_cnt;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int ch;
    bit rise;
    int cyc;
  } ev_t;
  ev_t exp_q[$];

  gpio_in_cond #(
    .NUM_GPIO    (2),
    .SYNC_STAGES (2),
    .DB_CYCLES   (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pad_i      (pad_i),
    .pad_ie     (pad_ie),
    .bypass     (bypass),
    .ival       (ival),
    .rise_p     (rise_p),
    .fall_p     (fall_p),
    .glitch_cnt (glitch_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_pulse(input int ch, input bit rise, input int edges);
    ev_t e;
    e.ch   = ch;
    e.rise = rise;
    e.cyc  = cyc + edges;
    exp_q.push_back(e);
  endtask

  // Monitor: every observed pulse must match the head of the expected queue.
  always @(negedge clk) begin
    for (int ch = 0; ch < 2; ch++) begin
      if (rise_p[ch] || fall_p[ch]) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_pulse ch=%0d rise=%0b fall=%0b at cyc %0d, none expected",
                   ch, rise_p[ch], fall_p[ch], cyc);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          if (e.ch != ch || e.rise != rise_p[ch] || e.rise == fall_p[ch] || e.cyc != cyc) begin
            failures++;
            $display("FAIL pulse actual ch=%0d rise=%0b fall=%0b cyc=%0d required ch=%0d rise=%0b cyc=%0d",
                     ch, rise_p[ch], fall_p[ch], cyc, e.ch, e.rise, e.cyc);
          end
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    pad_i  = 2'b00;
    pad_ie = 2'b11;
    bypass = 1'b0;
    tick(3);
    chk("reset_ival", ival, 2'b00);
    chk("reset_glitch", glitch_cnt, 16'h0000);
    chk("reset_pulses", {rise_p, fall_p}, 4'b0000);
    rst = 1'b0;
    tick(2);

    // Clean step on channel 0
    pad_i[0] = 1'b1;
    expect_pulse(0, 1'b1, 7);
    tick(6);
    chk("step_ival_before", ival[0], 1'b0);
    tick(1);
    chk("step_ival_edge7", ival[0], 1'b1);
    chk("step_ch1_quiet", ival[1], 1'b0);
    tick(2);

    // 4-cycle glitch on channel 1 is rejected
    pad_i[1] = 1'b1;
    tick(4);
    pad_i[1] = 1'b0;
    tick(6);
    chk("glitch_ival1", ival[1], 1'b0);
    chk("glitch_cnt1", glitch_cnt[15:8], 8'd1);

    // 5-cycle pulse is accepted: rise, then fall 7 edges after the falling edge
    pad_i[1] = 1'b1;
    expect_pulse(1, 1'b1, 7);
    tick(5);
    pad_i[1] = 1'b0;
    expect_pulse(1, 1'b0, 7);
    tick(2);
    chk("accept_ival1_high", ival[1], 1'b1);
    tick(7);
    chk("accept_ival1_low", ival[1], 1'b0);
    chk("accept_cnt1_same", glitch_cnt[15:8], 8'd1);

    // Input-enable gating on channel 0
    pad_i[0] = 1'b0;
    expect_pulse(0, 1'b0, 7);
    tick(10);
    pad_ie = 2'b10;
    pad_i[0] = 1'b1;
    tick(9);
    chk("ie_gated_ival0", ival[0], 1'b0);
    pad_ie = 2'b11;
    #1;
    chk("ie_raise_ival0", ival[0], 1'b1);
    tick(3);

    // Bypass: channel 0 toggles every 3 cycles, ival follows s with 2-edge latency
    bypass = 1'b1;
    begin
      logic prev;
      logic v;
      prev = 1'b1;
      for (int i = 0; i < 6; i++) begin
        v = (i % 2 == 0) ? 1'b0 : 1'b1;
        pad_i[0] = v;
        tick(1);
        chk("bypass_hold", ival[0], prev);
        tick(1);
        chk("bypass_follow", ival[0], v);
        tick(1);
        prev = v;
      end
    end
    tick(8);
    chk("bypass_glitch0", glitch_cnt[7:0], 8'd3);
    bypass = 1'b0;
    chk("bypass_off_ival0", ival[0], 1'b1);

    // 300 rejected low glitches on channel 0 saturate its counter
    for (int i = 0; i < 300; i++) begin
      pad_i[0] = 1'b0;
      tick(2);
      pad_i[0] = 1'b1;
      tick(2);
    end
    tick(6);
    chk("sat_glitch0", glitch_cnt[7:0], 8'd255);
    chk("sat_glitch1", glitch_cnt[15:8], 8'd1);
    chk("sat_ival0", ival[0], 1'b1);

    // Reset in the middle of channel 1's HI_PEND
    pad_i[1] = 1'b1;
    tick(4);
    rst = 1'b1;
    tick(1);
    chk("rst_ival", ival, 2'b00);
    chk("rst_glitch", glitch_cnt, 16'h0000);
    chk("rst_pulses", {rise_p, fall_p}, 4'b0000);
    rst = 1'b0;
    expect_pulse(0, 1'b1, 7);
    expect_pulse(1, 1'b1, 7);
    tick(6);
    chk("post_rst_before", ival, 2'b00);
    tick(1);
    chk("post_rst_ival", ival, 2'b11);
    tick(4);

    chk("pending_pulses", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gpio_in_cond.md
# gpio_in_cond

GPIO input conditioner between the board-level IOBUF outputs and the `io_pads_gpio_N_i_ival` inputs of `e203_soc_top`. Each channel synchronises the raw pad level into the SoC clock domain, debounces it with a per-channel state machine and counter, and gates the result with the SoC's input-enable. It also produces one-cycle edge pulses and a saturating glitch counter for board bring-up. It replaces the direct `iobuf_gpio_N_o & o_ie` connection in `system`.

## Interface

Parameters:

- `NUM_GPIO`, 2, number of conditioned channels.
- `SYNC_STAGES`, 2, synchroniser depth; must be at least 2.
- `DB_CYCLES`, 16000, stable-sample requirement (1 ms at 16 MHz); must be at least 2.
- `CNT_W`, `$clog2(DB_CYCLES)`, debounce counter width.

Ports:

- `clk`  in  1  SoC high-frequency clock (`clk_16M`).
- `rst`  in  1  synchronous, active-high reset (driven by `reset_periph`).
- `pad_i`  in  NUM_GPIO  raw pad levels from IOBUF `O`; asynchronous to `clk`.
- `pad_ie`  in  NUM_GPIO  per-channel input enable from the SoC `o_ie`.
- `bypass`  in  1  quasi-static; 1 selects the synchronised level instead of the debounced level for `ival`.
- `ival`  out  NUM_GPIO  conditioned level to the SoC `i_ival`.
- `rise_p`  out  NUM_GPIO  one-cycle pulse on a debounced 0→1 transition.
- `fall_p`  out  NUM_GPIO  one-cycle pulse on a debounced 1→0 transition.
- `glitch_cnt`  out  NUM_GPIO*8  per-channel count of rejected pulses; channel k occupies bits [8k+7:8k].

## Operation

Synchroniser:
- Each channel uses a `SYNC_STAGES`-deep flop chain; the last stage is `s`.
- No other logic samples `pad_i` directly.

Per-channel FSM states: LOW, HI_PEND, HIGH, LO_PEND. The debounced level `db` is 1 in HIGH and LO_PEND.
- LOW: if `s`=1, go to HI_PEND and set `cnt`=0.
- HI_PEND:
  - `s`=0: return to LOW, clear `cnt`, increment `glitch_cnt`.
  - `s`=1 and `cnt`=DB_CYCLES-1: go to HIGH.
  - `s`=1 otherwise: `cnt`+1.
- HIGH and LO_PEND mirror LOW and HI_PEND with the polarity inverted.
- Pulse acceptance: a pulse at `s` lasting ≤ DB_CYCLES cycles is rejected; one lasting ≥ DB_CYCLES+1 cycles is accepted.

Outputs:
- `db` is registered, derived from the FSM state.
- `ival` = (`bypass` ? `s` : `db`) & `pad_ie`. This is the only combinational path, AND-gated in the same way as the pad wrapper.
- `rise_p`/`fall_p` are registered. They assert in the same cycle `db` changes, and only when `pad_ie`=1 in that cycle. They are always derived from `db` and ignore `bypass`.
- `glitch_cnt` saturates at 255 and never wraps. It counts even when `pad_ie`=0.
- `cnt` is CNT_W bits wide and never exceeds DB_CYCLES-1.

Reset (synchronous, takes effect at the next edge, including mid-pending):
- Synchroniser flops: 0.
- FSM: LOW.
- `cnt`: 0.
- `db`, `rise_p`, `fall_p`: 0.
- `glitch_cnt`: 0.
- `ival` therefore reads 0.

A pad held high through reset produces a normal debounced `rise_p` after reset release.

## Timing

- Debounced latency: after `pad_i` settles, `db` and `ival` change on rising edge SYNC_STAGES+DB_CYCLES+1.
- Bypass latency: SYNC_STAGES edges.
- Pulse width: `rise_p`/`fall_p` are exactly 1 cycle wide. Consecutive pulses on one channel are at least DB_CYCLES+1 cycles apart.
- `pad_ie` and `bypass` affect `ival` in the same cycle (combinational).
- Channels are fully independent; simultaneous events on different channels never interact.
- An abort and a saturated `glitch_cnt` in the same cycle: the counter holds at 255.

## Structure

- Shared package `gpio_cond_pkg`:
  - 2-bit state encodings `ST_LOW`=0, `ST_HI_PEND`=1, `ST_HIGH`=2, `ST_LO_PEND`=3.
  - `GLITCH_MAX`=255.
- Sub-module `gpio_debounce_ch`, holding one channel's synchroniser, FSM, counter, pulse and glitch logic. The top instantiates it with `generate` over `NUM_GPIO` and applies the `bypass`/`pad_ie` output gating.

## Test plan

All scenarios use NUM_GPIO=2, SYNC_STAGES=2, DB_CYCLES=4.

1. Clean step: `pad_i[0]` 0→1 with `pad_ie`=2'b11. Expect `ival[0]`=1 and a 1-cycle `rise_p[0]` on edge 7; channel 1 unchanged.
2. Glitch rejection: 4-cycle high pulse on `pad_i[1]`. Expect `ival[1]` stays 0, `glitch_cnt[15:8]`=1, no pulses. A 5-cycle pulse is accepted: rise, then fall 7 edges after the falling edge.
3. Input-enable gating: `pad_ie`=0 during an accepted 0→1. Expect `ival`=0 and no `rise_p`; raising `pad_ie` afterwards makes `ival`=1 the same cycle with no pulse.
4. Bypass: `bypass`=1 with `pad_i[0]` toggling every 3 cycles. Expect `ival[0]` to follow with 2-cycle latency, `rise_p`/`fall_p` stay 0, and `glitch_cnt[7:0]` increments.
5. Saturation and reset: 300 rejected glitches give `glitch_cnt[7:0]`=255. `rst` asserted mid-HI_PEND clears all outputs at the next edge; `pad_i` held high gives `rise_p` 7 edges after `rst` deasserts.
